sdr_decoder_mx: RTL and testbench

- Eight-lane bit-serial signed-digit (SDR) decoder. Sits directly downstream of the eight-lane SDR encoder array.
- Consumes per-lane digit/sign bit streams, most-significant digit first, DIGITS cycles per word.
- Reconstructs one signed binary word per lane by shift-and-add. Also checks the nonzero-digit count against the active budget.
- Feeds reconstructed operands and per-lane budget-error flags to the accumulation/verification logic.

---
 rtl/sdr_decoder_mx_if.sv | 26 ++
 rtl/sdr_decoder_mx.sv | 91 +++++++++
 tb/tb_sdr_decoder_mx.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/sdr_decoder_mx_if.sv
// Serial SDR digit bus into the decoder and reconstructed-word bus out of it.
// The master drives the digit streams; the slave (decoder) returns the words.
interface sdr_decoder_mx_if #(
  parameter int unsigned LANES = 8,
  parameter int unsigned OUT_W = 9
);
  logic                   enable;
  logic                   frame_start;
  logic                   budget;
  logic [LANES-1:0]       output_stream;
  logic [LANES-1:0]       sign_stream;
  logic                   out_valid;
  logic [LANES*OUT_W-1:0] out_data;
  logic [LANES-1:0]       budget_err;
  logic                   frame_drop;

  modport master (
    output enable, frame_start, budget, output_stream, sign_stream,
    input  out_valid, out_data, budget_err, frame_drop
  );

  modport slave (
    input  enable, frame_start, budget, output_stream, sign_stream,
    output out_valid, out_data, budget_err, frame_drop
  );
endinterface

// File: rtl/sdr_decoder_mx.sv
// Eight-lane bit-serial signed-digit decoder: MSD-first shift-and-add per lane,
// with a per-lane nonzero-digit budget check on every completed word.
module sdr_decoder_mx #(
  parameter int unsigned LANES  = 8,
  parameter int unsigned DIGITS = 8,
  parameter int unsigned OUT_W  = DIGITS + 1
) (
  input logic             clk,
  input logic             reset,
  sdr_decoder_mx_if.slave bus
);
  localparam int unsigned NZ_W  = $clog2(DIGITS + 1);
  localparam int unsigned CNT_W = $clog2(DIGITS + 1);

  typedef enum logic [0:0] {IDLE, ACCUM} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic                    budget_q;
  logic signed [OUT_W-1:0] acc     [LANES];
  logic [NZ_W-1:0]         nz      [LANES];

  logic signed [OUT_W-1:0] dig_ext  [LANES];
  logic signed [OUT_W-1:0] acc_next [LANES];
  logic [NZ_W-1:0]         nz_first [LANES];
  logic [NZ_W-1:0]         nz_next  [LANES];
  logic [NZ_W-1:0]         limit;

  // Per-lane digit value (+1/-1/0) and the shift-and-add / count step it implies.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      dig_ext[i]  = '0;
      if (bus.output_stream[i]) begin
        dig_ext[i] = bus.sign_stream[i] ? -OUT_W'(1) : OUT_W'(1);
      end
      acc_next[i] = (acc[i] <<< 1) + dig_ext[i];
      nz_first[i] = NZ_W'(bus.output_stream[i]);
      nz_next[i]  = nz[i] + nz_first[i];
    end
    limit = budget_q ? NZ_W'(3) : NZ_W'(2);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      budget_q       <= 1'b0;
      bus.out_valid  <= 1'b0;
      bus.out_data   <= '0;
      bus.budget_err <= '0;
      bus.frame_drop <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        acc[i] <= '0;
        nz[i]  <= '0;
      end
    end else begin
      bus.out_valid  <= 1'b0;
      bus.frame_drop <= 1'b0;
      // A frame_start on any enabled cycle (re)loads all lanes with the MSD.
      if (bus.enable && bus.frame_start) begin
        if (state == ACCUM) begin
          bus.frame_drop <= 1'b1;
        end
        state    <= ACCUM;
        cnt      <= CNT_W'(1);
        budget_q <= bus.budget;
        for (int i = 0; i < LANES; i++) begin
          acc[i] <= dig_ext[i];
          nz[i]  <= nz_first[i];
        end
      end else if (bus.enable && state == ACCUM) begin
        for (int i = 0; i < LANES; i++) begin
          acc[i] <= acc_next[i];
          nz[i]  <= nz_next[i];
        end
        if (cnt == CNT_W'(DIGITS - 1)) begin
          // Last digit: publish the word and free IDLE for a zero-bubble restart.
          state         <= IDLE;
          cnt           <= '0;
          bus.out_valid <= 1'b1;
          for (int i = 0; i < LANES; i++) begin
            bus.out_data[i*OUT_W +: OUT_W] <= acc_next[i];
            bus.budget_err[i]              <= (nz_next[i] > limit);
          end
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_sdr_decoder_mx.sv
// Scoreboard bench for sdr_decoder_mx: directed digit streams push expected
// words and cycle stamps; a negedge monitor pops and compares on each pulse.
module tb_sdr_decoder_mx;
  localparam int unsigned LANES  = 8;
  localparam int unsigned DIGITS = 8;
  localparam int unsigned OUT_W  = 9;
  localparam int unsigned DW     = LANES * OUT_W;

  typedef struct {
    logic [DW-1:0]    data;
    logic [LANES-1:0] err;
    int               cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  int   drop_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sdr_decoder_mx_if #(.LANES(LANES), .OUT_W(OUT_W)) bus ();

  sdr_decoder_mx #(.LANES(LANES), .DIGITS(DIGITS), .OUT_W(OUT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [DW-1:0] lane_word(input int lane, input logic signed [OUT_W-1:0] v);
    logic [DW-1:0] r;
    r = '0;
    r[lane*OUT_W +: OUT_W] = v;
    return r;
  endfunction

  // Monitor: every out_valid / frame_drop pulse must match the head of its queue.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", DW'(1), DW'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_data", bus.out_data, e.data);
        check("budget_err", DW'(bus.budget_err), DW'(e.err));
        check("valid_cycle", DW'(cyc), DW'(e.cyc));
      end
    end
    if (bus.frame_drop === 1'b1) begin
      if (drop_q.size() == 0) begin
        check("unexpected_frame_drop", DW'(1), DW'(0));
      end else begin
        int dc;
        dc = drop_q.pop_front();
        check("drop_cycle", DW'(cyc), DW'(dc));
      end
    end
  end

  task automatic drive_cycle(input logic en, input logic fs, input logic b,
                             input logic [7:0] d, input logic [7:0] s);
    bus.enable        = en;
    bus.frame_start   = fs;
    bus.budget        = b;
    bus.output_stream = d;
    bus.sign_stream   = s;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive_cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  // Digit k (k=0 is the MSD) sits in byte k; budget flips after the MSD to
  // show it is only sampled at frame_start. Disabled stall cycles carry junk.
  task automatic send_word(input logic [63:0] dv, input logic [63:0] sv, input logic b,
                           input int stall_at, input int stall_n);
    for (int k = 0; k < 8; k++) begin
      if (k == stall_at) repeat (stall_n) drive_cycle(1'b0, 1'b1, ~b, 8'hFF, 8'hFF);
      drive_cycle(1'b1, k == 0, (k == 0) ? b : ~b, dv[k*8 +: 8], sv[k*8 +: 8]);
    end
  endtask

  localparam logic [63:0] T1_D = 64'h0100_0000_0000_0001;
  localparam logic [63:0] T1_S = 64'h0100_0000_0000_0000;
  localparam logic [63:0] T2_D = 64'h8080_8080_8088_8088;
  localparam logic [63:0] T2_S = 64'h8080_8080_8088_8080;
  localparam logic [63:0] T3_D = 64'h0000_0000_0002_0202;
  localparam logic [63:0] T3_S = 64'h0000_0000_0000_0000;
  localparam logic [63:0] M1_D = 64'h0100_0000_0000_0000;

  initial begin
    int c0;
    reset = 1'b1;
    bus.enable = 1'b0; bus.frame_start = 1'b0; bus.budget = 1'b0;
    bus.output_stream = '0; bus.sign_stream = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", DW'(bus.out_valid), DW'(0));
    check("reset_out_data", bus.out_data, DW'(0));
    check("reset_budget_err", DW'(bus.budget_err), DW'(0));
    check("reset_frame_drop", DW'(bus.frame_drop), DW'(0));
    reset = 1'b0;
    idle(2);

    // Lane 0: +1,0,0,0,0,0,0,-1 -> 127
    c0 = cyc;
    exp_q.push_back('{lane_word(0, 9'sd127), 8'h00, c0 + 8});
    send_word(T1_D, T1_S, 1'b0, -1, 0);
    idle(3);
    check("hold_out_data", bus.out_data, lane_word(0, 9'sd127));

    // Lane 3 -> 96, lane 7 all -1 -> -255 with 8 nonzero digits over budget 3
    c0 = cyc;
    exp_q.push_back('{lane_word(3, 9'sd96) | lane_word(7, -9'sd255), 8'h80, c0 + 8});
    send_word(T2_D, T2_S, 1'b1, -1, 0);
    idle(2);

    // Lane 1: three +1 digits = 224; within budget 3, over budget 2
    c0 = cyc;
    exp_q.push_back('{lane_word(1, 9'sd224), 8'h00, c0 + 8});
    send_word(T3_D, T3_S, 1'b1, -1, 0);
    idle(1);
    c0 = cyc;
    exp_q.push_back('{lane_word(1, 9'sd224), 8'h02, c0 + 8});
    send_word(T3_D, T3_S, 1'b0, -1, 0);
    idle(2);

    // Three disabled cycles before digit 4 delay completion by exactly 3
    c0 = cyc;
    exp_q.push_back('{lane_word(0, 9'sd127), 8'h00, c0 + 11});
    send_word(T1_D, T1_S, 1'b0, 4, 3);
    idle(2);

    // Early frame_start on digit 5 drops the partial word
    for (int k = 0; k < 4; k++) drive_cycle(1'b1, k == 0, 1'b1, T2_D[k*8 +: 8], T2_S[k*8 +: 8]);
    c0 = cyc;
    drop_q.push_back(c0 + 1);
    exp_q.push_back('{lane_word(1, 9'sd224), 8'h02, c0 + 8});
    send_word(T3_D, T3_S, 1'b0, -1, 0);
    idle(2);

    // Back-to-back 127 then -1, then reset part-way through a third frame
    c0 = cyc;
    exp_q.push_back('{lane_word(0, 9'sd127), 8'h00, c0 + 8});
    exp_q.push_back('{lane_word(0, -9'sd1), 8'h00, c0 + 16});
    send_word(T1_D, T1_S, 1'b0, -1, 0);
    send_word(M1_D, M1_D, 1'b0, -1, 0);
    for (int k = 0; k < 4; k++) drive_cycle(1'b1, k == 0, 1'b0, T1_D[k*8 +: 8], T1_S[k*8 +: 8]);
    reset = 1'b1;
    drive_cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    reset = 1'b0;
    check("midreset_out_data", bus.out_data, DW'(0));
    check("midreset_budget_err", DW'(bus.budget_err), DW'(0));
    idle(12);

    // Decoder restarts cleanly after the aborted frame
    c0 = cyc;
    exp_q.push_back('{lane_word(0, 9'sd127), 8'h00, c0 + 8});
    send_word(T1_D, T1_S, 1'b0, -1, 0);
    idle(4);

    check("missing_out_valid", DW'(exp_q.size()), DW'(0));
    check("missing_frame_drop", DW'(drop_q.size()), DW'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
